// File: rtl/lc3_mmio_pkg.sv
// Shared LC-3 memory-map constants, access FSM encoding and address decode
// used by mem_ctrl.
package lc3_mmio_pkg;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  localparam int DEV_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic ram;
    logic kbsr;
    logic kbdr;
    logic dsr;
    logic ddr;
    logic mcr;
  } mem_sel_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Unlisted addresses in the IO page select nothing: read 0, writes dropped.
  function automatic mem_sel_t mmio_decode(input logic [15:0] a);
    mem_sel_t s;
    s      = '0;
    s.ram  = (a < IO_BASE);
    s.kbsr = (a == ADDR_KBSR);
    s.kbdr = (a == ADDR_KBDR);
    s.dsr  = (a == ADDR_DSR);
    s.ddr  = (a == ADDR_DDR);
    s.mcr  = (a == ADDR_MCR);
    return s;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Backing RAM: asynchronous read, synchronous write.
module mem_ram #(
  parameter int AW        = 16,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, RAM, MMIO devices and the R (mem_rdy) qualifier.
// Optional MEM_CTRL_KBD_INT_EN adds KBSR interrupt-enable and the kb_int output.
module mem_ctrl
  import lc3_mmio_pkg::*;
#(
  parameter int MEM_AW        = 16,
  parameter int READ_LATENCY  = 5,
  parameter int WRITE_LATENCY = 5,
  parameter     INIT_FILE     = ""
) (
  input  logic       clk,
  input  logic       srst,
  inout  wire [15:0] bus,
  input  logic       mem_ld_mar,
  input  logic       mem_ld_mdr,
  input  logic       mem_gate_mdr,
  input  logic       mem_mio_en,
  input  logic       mem_rw,
  output logic       mem_rdy,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       kb_ack,
  output logic       dsp_valid,
  output logic [7:0] dsp_data,
  input  logic       dsp_ready,
  output logic       mcr_run
`ifdef MEM_CTRL_KBD_INT_EN
  ,output logic      kb_int
`endif
);

  localparam int MAX_LAT = max_int(max_int(READ_LATENCY, WRITE_LATENCY), DEV_LATENCY);
  localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  logic [15:0] mar, mdr, mcr, rdata, ram_rdata;
  logic [7:0]  kbdr;
  logic        kb_rdy, kb_ie, kb_take;
  logic        commit, ram_we, kbdr_rd, ddr_wr, mcr_wr;
  mem_sel_t    sel;
  mem_state_e  state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_load;

  assign sel = mmio_decode(mar);

  always_comb begin
    if (!sel.ram)    cnt_load = CW'(DEV_LATENCY - 2);
    else if (mem_rw) cnt_load = CW'(WRITE_LATENCY - 2);
    else             cnt_load = CW'(READ_LATENCY - 2);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: if (mem_mio_en) begin
        state_n = ST_BUSY;
        cnt_n   = cnt_load;
      end
      ST_BUSY: begin
        if (!mem_mio_en)   state_n = ST_IDLE;
        else if (cnt == '0) state_n = ST_READY;
        else               cnt_n   = cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign mem_rdy = (state == ST_READY);

  // Side effects happen only on the edge closing a READY cycle the CPU still requests.
  assign commit  = mem_rdy & mem_mio_en;
  assign ram_we  = commit &  mem_rw & sel.ram;
  assign kbdr_rd = commit & ~mem_rw & sel.kbdr;
  assign ddr_wr  = commit &  mem_rw & sel.ddr;
  assign mcr_wr  = commit &  mem_rw & sel.mcr;
  assign kb_take = kb_valid & ~kb_rdy & ~kbdr_rd;

  mem_ram #(.AW(MEM_AW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mar[MEM_AW-1:0]),
    .wdata (mdr),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata = '0;
    if (sel.ram)       rdata = ram_rdata;
    else if (sel.kbsr) rdata = {kb_rdy, kb_ie, 14'b0};
    else if (sel.kbdr) rdata = {8'b0, kbdr};
    else if (sel.dsr)  rdata = {~dsp_valid, 15'b0};
    else if (sel.mcr)  rdata = mcr;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (mem_ld_mar) mar <= bus;
      if (mem_ld_mdr) mdr <= mem_mio_en ? rdata : bus;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      kb_rdy    <= 1'b0;
      kbdr      <= '0;
      kb_ack    <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
      mcr       <= 16'h8000;
    end else begin
      kb_ack <= kb_take;
      if (kbdr_rd) kb_rdy <= 1'b0;
      else if (kb_take) begin
        kb_rdy <= 1'b1;
        kbdr   <= kb_data;
      end
      // A DDR write while a char is still pending is dropped, keeping dsp_data stable.
      if (ddr_wr && !dsp_valid) begin
        dsp_data  <= mdr[7:0];
        dsp_valid <= 1'b1;
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
      end
      if (mcr_wr) mcr <= mdr;
    end
  end

`ifdef MEM_CTRL_KBD_INT_EN
  logic kbsr_wr;
  assign kbsr_wr = commit & mem_rw & sel.kbsr;

  always_ff @(posedge clk) begin
    if (srst) begin
      kb_ie  <= 1'b0;
      kb_int <= 1'b0;
    end else begin
      if (kbsr_wr) kb_ie <= mdr[14];
      kb_int <= kb_rdy & kb_ie;
    end
  end
`else
  assign kb_ie = 1'b0;
`endif

  assign mcr_run = mcr[15];
  assign bus     = (mem_gate_mdr && !srst) ? mdr : 16'bz;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table of bus accesses plus
// hand sequences for abort, keyboard handshake, display and reset.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        srst;
  wire  [15:0] bus;
  logic [15:0] bus_drv;
  logic        bus_en;
  logic        ld_mar, ld_mdr, gate_mdr, mio_en, rw;
  logic        mem_rdy, kb_valid, kb_ack, dsp_valid, dsp_ready, mcr_run;
  logic [7:0]  kb_data, dsp_data;
`ifdef MEM_CTRL_KBD_INT_EN
  logic        kb_int;
`endif

  assign bus = bus_en ? bus_drv : 16'bz;
  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk          (clk),
    .srst         (srst),
    .bus          (bus),
    .mem_ld_mar   (ld_mar),
    .mem_ld_mdr   (ld_mdr),
    .mem_gate_mdr (gate_mdr),
    .mem_mio_en   (mio_en),
    .mem_rw       (rw),
    .mem_rdy      (mem_rdy),
    .kb_valid     (kb_valid),
    .kb_data      (kb_data),
    .kb_ack       (kb_ack),
    .dsp_valid    (dsp_valid),
    .dsp_data     (dsp_data),
    .dsp_ready    (dsp_ready),
    .mcr_run      (mcr_run)
`ifdef MEM_CTRL_KBD_INT_EN
    ,.kb_int      (kb_int)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  logic kb_ack_post;
  vec_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] a, input logic w, input logic [15:0] wd,
                              input logic [15:0] e, input int l);
    vec_t v;
    v.addr = a; v.rw = w; v.wdata = wd; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] a);
    @(negedge clk); bus_en = 1; bus_drv = a; ld_mar = 1;
    @(negedge clk); ld_mar = 0; bus_en = 0;
  endtask

  task automatic load_mdr(input logic [15:0] d);
    @(negedge clk); bus_en = 1; bus_drv = d; ld_mdr = 1;
    @(negedge clk); ld_mdr = 0; bus_en = 0;
  endtask

  // One CPU access: expected latency/data queued at issue, checked when R appears.
  task automatic run_vec(input string tag, input vec_t v, input logic offer, input logic nomar);
    vec_t e;
    int   n;
    if (v.rw) load_mdr(v.wdata);
    if (nomar) @(negedge clk);
    else load_mar(v.addr);
    sb.push_back(v);
    rw = v.rw; ld_mdr = !v.rw; mio_en = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_rdy && n < 20);
    e = sb.pop_front();
    check({tag, " latency"}, n, e.lat);
    if (offer) begin kb_valid = 1; kb_data = 8'h43; end
    @(negedge clk);
    kb_ack_post = kb_ack;
    mio_en = 0; ld_mdr = 0; rw = 0;
    if (!e.rw) begin
      gate_mdr = 1; #1;
      check({tag, " data"}, bus, e.exp);
      gate_mdr = 0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs.push_back(mk(16'h3000, 1, 16'h1234, 16'h0000, 5));
    vecs.push_back(mk(16'h3000, 0, 16'h0000, 16'h1234, 5));
    vecs.push_back(mk(16'h4000, 1, 16'hBEEF, 16'h0000, 5));
    vecs.push_back(mk(16'h4000, 0, 16'h0000, 16'hBEEF, 5));
    vecs.push_back(mk(16'hFDFF, 1, 16'h00AA, 16'h0000, 5));
    vecs.push_back(mk(16'hFDFF, 0, 16'h0000, 16'h00AA, 5));
    vecs.push_back(mk(16'hFE04, 0, 16'h0000, 16'h8000, 2));
    vecs.push_back(mk(16'hFE06, 0, 16'h0000, 16'h0000, 2));
    vecs.push_back(mk(16'hFFFE, 0, 16'h0000, 16'h8000, 2));
    vecs.push_back(mk(16'hFE08, 1, 16'h5555, 16'h0000, 2));
    vecs.push_back(mk(16'hFE08, 0, 16'h0000, 16'h0000, 2));
    vecs.push_back(mk(16'hFFFC, 0, 16'h0000, 16'h0000, 2));
    vecs.push_back(mk(16'hFE00, 1, 16'hC000, 16'h0000, 2));
`ifdef MEM_CTRL_KBD_INT_EN
    vecs.push_back(mk(16'hFE00, 0, 16'h0000, 16'h4000, 2));
`else
    vecs.push_back(mk(16'hFE00, 0, 16'h0000, 16'h0000, 2));
`endif
    vecs.push_back(mk(16'hFE00, 1, 16'h0000, 16'h0000, 2));

    srst = 1; bus_en = 0; bus_drv = '0; ld_mar = 0; ld_mdr = 0; gate_mdr = 0;
    mio_en = 0; rw = 0; kb_valid = 0; kb_data = '0; dsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst mem_rdy", mem_rdy, 0);
    check("rst kb_ack", kb_ack, 0);
    check("rst dsp_valid", dsp_valid, 0);
    check("rst dsp_data", dsp_data, 0);
    check("rst mcr_run", mcr_run, 1);
    srst = 0;
    gate_mdr = 1; #1;
    check("rst mdr", bus, 16'h0000);
    gate_mdr = 0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);

    // Write aborted in cycle 3: no R, RAM keeps xBEEF.
    load_mdr(16'h1111);
    load_mar(16'h4000);
    rw = 1; mio_en = 1;
    repeat (3) begin @(negedge clk); check("abort rdy busy", mem_rdy, 0); end
    mio_en = 0; rw = 0;
    repeat (6) begin @(negedge clk); check("abort rdy after", mem_rdy, 0); end
    run_vec("abort readback", mk(16'h4000, 0, 0, 16'hBEEF, 5), 1'b0, 1'b0);

    // Keyboard handshake.
    @(negedge clk); kb_data = 8'h41; kb_valid = 1;
    @(negedge clk); check("kb ack1", kb_ack, 1); kb_valid = 0;
    @(negedge clk); check("kb ack1 pulse", kb_ack, 0);
    run_vec("kbsr ready", mk(16'hFE00, 0, 0, 16'h8000, 2), 1'b0, 1'b0);
    run_vec("kbdr 41", mk(16'hFE02, 0, 0, 16'h0041, 2), 1'b0, 1'b0);
    run_vec("kbsr clear", mk(16'hFE00, 0, 0, 16'h0000, 2), 1'b0, 1'b0);
    @(negedge clk); kb_data = 8'h42; kb_valid = 1;
    @(negedge clk); check("kb ack2", kb_ack, 1); kb_valid = 0;
    run_vec("kbdr 42", mk(16'hFE02, 0, 0, 16'h0042, 2), 1'b1, 1'b0);
    check("kb blocked at commit", kb_ack_post, 0);
    n = 0;
    while (!kb_ack && n < 5) begin @(negedge clk); n++; end
    check("kb late ack", kb_ack, 1);
    kb_valid = 0;
    run_vec("kbdr 43", mk(16'hFE02, 0, 0, 16'h0043, 2), 1'b0, 1'b0);

    // Display.
    run_vec("ddr w1", mk(16'hFE06, 1, 16'h0048, 0, 2), 1'b0, 1'b0);
    check("dsp_valid set", dsp_valid, 1);
    check("dsp_data 48", dsp_data, 8'h48);
    run_vec("dsr busy", mk(16'hFE04, 0, 0, 16'h0000, 2), 1'b0, 1'b0);
    run_vec("ddr w2", mk(16'hFE06, 1, 16'h0055, 0, 2), 1'b0, 1'b0);
    check("dsp_data held", dsp_data, 8'h48);
    @(negedge clk); dsp_ready = 1;
    @(negedge clk); check("dsp_valid clr", dsp_valid, 0); dsp_ready = 0;
    run_vec("dsr idle", mk(16'hFE04, 0, 0, 16'h8000, 2), 1'b0, 1'b0);

    // MCR and reset mid-access.
    run_vec("mcr w", mk(16'hFFFE, 1, 16'h0000, 0, 2), 1'b0, 1'b0);
    check("mcr_run off", mcr_run, 0);
    run_vec("mcr r", mk(16'hFFFE, 0, 0, 16'h0000, 2), 1'b0, 1'b0);
    run_vec("ram0 w", mk(16'h0000, 1, 16'h0AAA, 0, 5), 1'b0, 1'b0);
    load_mar(16'h3000);
    rw = 0; ld_mdr = 1; mio_en = 1;
    repeat (2) @(negedge clk);
    srst = 1; mio_en = 0; ld_mdr = 0;
    @(negedge clk);
    check("srst mem_rdy", mem_rdy, 0);
    check("srst mcr_run", mcr_run, 1);
    srst = 0;
    gate_mdr = 1; #1;
    check("srst mdr", bus, 16'h0000);
    gate_mdr = 0;
    repeat (3) begin @(negedge clk); check("srst no rdy", mem_rdy, 0); end
    run_vec("srst mar", mk(16'h0000, 0, 0, 16'h0AAA, 5), 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
